// File: rtl/vae_fixed_pkg.sv
// Shared Q5.27 fixed-point helpers for the VAE datapath (encoder head, sampler, decoder).
package vae_fixed_pkg;

    localparam int BITSIZE = 32;
    localparam int FRAC    = 27;
    // Wide enough for any accumulator this family of blocks builds.
    localparam int EXT_W   = 2*BITSIZE + 16;

    localparam logic [BITSIZE-1:0] WORD_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] WORD_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } head_state_e;

    // Drop FRAC bits (floor) and clip the result to one signed word.
    function automatic logic [BITSIZE-1:0] sat_shift(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] s;
        logic [BITSIZE-1:0]      r;
        s = v >>> FRAC;
        if (s[EXT_W-1:BITSIZE-1] == {(EXT_W-BITSIZE+1){s[EXT_W-1]}}) begin
            r = s[BITSIZE-1:0];
        end else if (s[EXT_W-1]) begin
            r = WORD_MIN;
        end else begin
            r = WORD_MAX;
        end
        return r;
    endfunction

    // Place a Q5.27 bias on the product scale (Q10.54) of the accumulator.
    function automatic logic signed [EXT_W-1:0] align_bias(input logic [BITSIZE-1:0] b);
        logic signed [EXT_W-1:0] e;
        e = {{(EXT_W-BITSIZE){b[BITSIZE-1]}}, b};
        return e <<< FRAC;
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate with a registered accumulator and a load port for bias preset.
module fxp_mac #(
    parameter int BW = 32,
    parameter int AW = 66
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          en,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [AW-1:0] acc_next
);

    logic signed [2*BW-1:0] prod_s;
    logic [AW-1:0]          acc_r;

    assign prod_s   = $signed(a) * $signed(b);
    assign acc_next = acc_r + {{(AW-2*BW){prod_s[2*BW-1]}}, prod_s};

    // Accumulator: load takes priority so a row can finish and the next bias preset on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (load) begin
            acc_r <= load_val;
        end else if (en) begin
            acc_r <= acc_next;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/encoder_latent_head.sv
// Latent mean/variance dense layers of the VAE encoder on one shared MAC.
// Rows run mu_0, var_0, mu_1, var_1, ... with K_input MAC cycles per row.
module encoder_latent_head
    import vae_fixed_pkg::*;
#(
    parameter int K_input  = 2,
    parameter int M_output = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [K_input*BITSIZE-1:0]          x_in,
    input  logic [M_output*K_input*BITSIZE-1:0] w_mu,
    input  logic [M_output*K_input*BITSIZE-1:0] w_var,
    input  logic [M_output*BITSIZE-1:0]         b_mu,
    input  logic [M_output*BITSIZE-1:0]         b_var,
    output logic                                busy,
    output logic                                done,
    output logic                                out_valid,
    output logic [M_output*BITSIZE-1:0]         ac,
    output logic [M_output*BITSIZE-1:0]         ad
);

    localparam int ACC_W = 2*BITSIZE + $clog2(K_input) + 1;
    localparam int COL_W = (K_input > 1) ? $clog2(K_input) : 1;
    localparam int ROWS  = 2*M_output;
    localparam int ROW_W = $clog2(ROWS);

    head_state_e state_r, state_s;

    logic [K_input*BITSIZE-1:0]          x_r;
    logic [M_output*K_input*BITSIZE-1:0] wmu_r, wvar_r;
    logic [M_output*BITSIZE-1:0]         bmu_r, bvar_r;
    logic [M_output*BITSIZE-1:0]         ac_r, ad_r;
    logic [COL_W-1:0]                    col_r;
    logic [ROW_W-1:0]                    row_r;
    logic                                busy_r, done_r, out_valid_r;

    logic             accept_s, last_col_s, last_row_s, is_var_s, next_var_s;
    logic [ROW_W-1:0] slot_s, next_row_s, next_slot_s;
    logic [31:0]      w_idx_s, x_idx_s, b_idx_s;
    logic [BITSIZE-1:0] x_op_s, w_op_s, next_bias_s, res_s;
    logic [EXT_W-1:0] bias_ext_s, acc_ext_s;
    logic             mac_load_s, mac_en_s;
    logic [ACC_W-1:0] mac_load_val_s, mac_acc_next_s;

    fxp_mac #(
        .BW (BITSIZE),
        .AW (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .load     (mac_load_s),
        .load_val (mac_load_val_s),
        .en       (mac_en_s),
        .a        (x_op_s),
        .b        (w_op_s),
        .acc_next (mac_acc_next_s)
    );

    // Row/column decode, operand selection and the finished-row result word.
    always_comb begin
        last_col_s  = (col_r == COL_W'(K_input-1));
        last_row_s  = (row_r == ROW_W'(ROWS-1));
        slot_s      = row_r >> 1;
        is_var_s    = row_r[0];
        next_row_s  = row_r + ROW_W'(1);
        next_slot_s = next_row_s >> 1;
        next_var_s  = next_row_s[0];
        x_idx_s     = 32'(col_r);
        w_idx_s     = 32'(slot_s) * 32'(K_input) + 32'(col_r);
        b_idx_s     = 32'(next_slot_s);
        x_op_s      = x_r[x_idx_s*BITSIZE +: BITSIZE];
        if (is_var_s) begin
            w_op_s = wvar_r[w_idx_s*BITSIZE +: BITSIZE];
        end else begin
            w_op_s = wmu_r[w_idx_s*BITSIZE +: BITSIZE];
        end
        if (next_var_s) begin
            next_bias_s = bvar_r[b_idx_s*BITSIZE +: BITSIZE];
        end else begin
            next_bias_s = bmu_r[b_idx_s*BITSIZE +: BITSIZE];
        end
        acc_ext_s = {{(EXT_W-ACC_W){mac_acc_next_s[ACC_W-1]}}, mac_acc_next_s};
        res_s     = sat_shift(acc_ext_s);
        if (is_var_s && res_s[BITSIZE-1]) begin
            res_s = '0;
        end else begin
            res_s = res_s;
        end
    end

    // Next state and MAC control.
    always_comb begin
        state_s        = state_r;
        accept_s       = 1'b0;
        mac_load_s     = 1'b0;
        mac_en_s       = 1'b0;
        bias_ext_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_RUN;
                    accept_s   = 1'b1;
                    mac_load_s = 1'b1;
                    bias_ext_s = align_bias(b_mu[BITSIZE-1:0]);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                mac_en_s = 1'b1;
                if (last_col_s) begin
                    mac_load_s = 1'b1;
                    if (last_row_s) begin
                        state_s = ST_DONE;
                    end else begin
                        bias_ext_s = align_bias(next_bias_s);
                    end
                end else begin
                    mac_load_s = 1'b0;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        mac_load_val_s = bias_ext_s[ACC_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, counters, result slots and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r         <= '0;
            wmu_r       <= '0;
            wvar_r      <= '0;
            bmu_r       <= '0;
            bvar_r      <= '0;
            ac_r        <= '0;
            ad_r        <= '0;
            col_r       <= '0;
            row_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
            if (accept_s) begin
                x_r         <= x_in;
                wmu_r       <= w_mu;
                wvar_r      <= w_var;
                bmu_r       <= b_mu;
                bvar_r      <= b_var;
                col_r       <= '0;
                row_r       <= '0;
                out_valid_r <= 1'b0;
            end else if (state_r == ST_RUN) begin
                if (last_col_s) begin
                    col_r <= '0;
                    row_r <= next_row_s;
                    if (is_var_s) begin
                        ad_r[32'(slot_s)*BITSIZE +: BITSIZE] <= res_s;
                    end else begin
                        ac_r[32'(slot_s)*BITSIZE +: BITSIZE] <= res_s;
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
                if (state_s == ST_DONE) begin
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= out_valid_r;
                end
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = out_valid_r;
    assign ac        = ac_r;
    assign ad        = ad_r;

endmodule
